// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types and helpers for the ghost AI core.
//   dir_t     : move direction, UP=0 RIGHT=1 DOWN=2 LEFT=3 (clockwise order)
//   mode_t    : behaviour mode, SCATTER=0 CHASE=1 FRIGHT=2
//   DIR_PRIO  : tie-break order for equal-cost moves, index 0 = highest priority
//   reverse() : opposite direction
//   lfsr_step(): one step of the 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1
package ghost_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_FRIGHT  = 2'd2
    } mode_t;

    // Element 0 is checked first: UP > LEFT > DOWN > RIGHT.
    localparam logic [3:0][1:0] DIR_PRIO = {2'd1, 2'd2, 2'd3, 2'd0};

    // Opposite directions differ only in bit 1 thanks to the clockwise encoding.
    function automatic dir_t reverse(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

    // Right-shifting Galois form; 0xB8 holds the taps 8,6,5,4.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return l[0] ? ({1'b0, l[7:1]} ^ 8'hB8) : {1'b0, l[7:1]};
    endfunction

endpackage

// File: rtl/ghost_target_fsm_if.sv
// ghost_target_fsm_if: signal bundle between the game logic and one ghost core.
//   tick, step_en, power_pellet : one-cycle strobes into the core
//   pac_x, pac_y, pac_dir       : Pac-Man tile and heading
//   ghost_x, ghost_y            : this ghost's tile
//   can_move_u/r/d/l            : maze legality of each neighbour tile
//   dir_to_move, dir_valid, mode: core outputs
// master = game logic side (drives inputs), slave = ghost core.
//
// Handshake: step_en is a request strobe with no ready; the core always accepts
// it. Exactly one cycle later dir_valid pulses for one cycle and dir_to_move
// holds the answer (it keeps that value until the next accepted request).
interface ghost_target_fsm_if #(
    parameter int COORD_W = 5
);
    logic               tick;
    logic               step_en;
    logic               power_pellet;
    logic [COORD_W-1:0] pac_x;
    logic [COORD_W-1:0] pac_y;
    logic [1:0]         pac_dir;
    logic [COORD_W-1:0] ghost_x;
    logic [COORD_W-1:0] ghost_y;
    logic               can_move_u;
    logic               can_move_r;
    logic               can_move_d;
    logic               can_move_l;
    logic [1:0]         dir_to_move;
    logic               dir_valid;
    logic [1:0]         mode;

    modport master (
        output tick, step_en, power_pellet, pac_x, pac_y, pac_dir,
               ghost_x, ghost_y, can_move_u, can_move_r, can_move_d, can_move_l,
        input  dir_to_move, dir_valid, mode
    );

    modport slave (
        input  tick, step_en, power_pellet, pac_x, pac_y, pac_dir,
               ghost_x, ghost_y, can_move_u, can_move_r, can_move_d, can_move_l,
        output dir_to_move, dir_valid, mode
    );
endinterface

// File: rtl/ghost_dir_select.sv
// ghost_dir_select: purely combinational move chooser.
//   i_ghost_x/y   : current ghost tile
//   i_tgt_x/y     : target tile (ignored in frightened mode)
//   i_can_move    : maze legality, bit index = dir_t
//   i_cur_dir     : direction currently being travelled
//   i_force_rev   : a mode change is pending; take the reverse if it is legal
//   i_fright      : frightened mode, pick pseudo-randomly instead of by cost
//   i_rand_dir    : starting direction for the frightened rotation
//   o_dir         : chosen direction
//   o_found       : a legal move exists (otherwise the caller holds its direction)
module ghost_dir_select
    import ghost_pkg::*;
#(
    parameter int COORD_W = 5
) (
    input  logic [COORD_W-1:0] i_ghost_x,
    input  logic [COORD_W-1:0] i_ghost_y,
    input  logic [COORD_W-1:0] i_tgt_x,
    input  logic [COORD_W-1:0] i_tgt_y,
    input  logic [3:0]         i_can_move,
    input  dir_t               i_cur_dir,
    input  logic               i_force_rev,
    input  logic               i_fright,
    input  dir_t               i_rand_dir,
    output dir_t               o_dir,
    output logic               o_found
);
    localparam int                 CW    = 2 * COORD_W + 1;
    localparam logic [COORD_W-1:0] MAX_C = '1;
    localparam logic [COORD_W:0]   ONE   = 1;

    // Coordinates carry one extra bit so a neighbour step never wraps before
    // the distance is taken (edge neighbours are excluded by w_legal anyway).
    function automatic logic [CW-1:0] sq_dist(input logic [COORD_W:0] a_x, a_y, b_x, b_y);
        logic [COORD_W:0] d_x;
        logic [COORD_W:0] d_y;
        logic [CW-1:0]    e_x;
        logic [CW-1:0]    e_y;
        d_x = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);
        d_y = (a_y >= b_y) ? (a_y - b_y) : (b_y - a_y);
        e_x = CW'(d_x);
        e_y = CW'(d_y);
        return e_x * e_x + e_y * e_y;
    endfunction

    logic [COORD_W:0] w_gx, w_gy, w_tx, w_ty;
    logic [CW-1:0]    w_cost [4];
    logic [3:0]       w_legal;
    logic [3:0]       w_non_rev;
    logic [3:0]       w_allowed;
    dir_t             w_rev;
    dir_t             w_d;
    dir_t             w_sel;
    logic             w_found;
    logic [CW-1:0]    w_best_cost;

    assign w_gx = {1'b0, i_ghost_x};
    assign w_gy = {1'b0, i_ghost_y};
    assign w_tx = {1'b0, i_tgt_x};
    assign w_ty = {1'b0, i_tgt_y};

    assign w_cost[DIR_UP]    = sq_dist(w_gx, w_gy - ONE, w_tx, w_ty);
    assign w_cost[DIR_RIGHT] = sq_dist(w_gx + ONE, w_gy, w_tx, w_ty);
    assign w_cost[DIR_DOWN]  = sq_dist(w_gx, w_gy + ONE, w_tx, w_ty);
    assign w_cost[DIR_LEFT]  = sq_dist(w_gx - ONE, w_gy, w_tx, w_ty);

    // A move is legal only if the maze allows it and it stays on the board.
    assign w_legal[DIR_UP]    = i_can_move[DIR_UP]    && (i_ghost_y != '0);
    assign w_legal[DIR_RIGHT] = i_can_move[DIR_RIGHT] && (i_ghost_x != MAX_C);
    assign w_legal[DIR_DOWN]  = i_can_move[DIR_DOWN]  && (i_ghost_y != MAX_C);
    assign w_legal[DIR_LEFT]  = i_can_move[DIR_LEFT]  && (i_ghost_x != '0);

    assign w_rev     = reverse(i_cur_dir);
    assign w_non_rev = w_legal & ~(4'b0001 << w_rev);
    // Reversing is allowed only when it is the sole way out.
    assign w_allowed = (w_non_rev != 4'b0000) ? w_non_rev : w_legal;

    always_comb begin
        w_sel       = i_cur_dir;
        w_found     = 1'b0;
        w_best_cost = '1;
        w_d         = DIR_UP;
        if (i_force_rev && w_legal[w_rev]) begin
            w_sel   = w_rev;
            w_found = 1'b1;
        end else if (i_fright) begin
            // Clockwise from the random start to the first allowed move.
            for (int k = 0; k < 4; k++) begin
                w_d = dir_t'(i_rand_dir + 2'(k));
                if (!w_found && w_allowed[w_d]) begin
                    w_sel   = w_d;
                    w_found = 1'b1;
                end
            end
        end else begin
            // Strict '<' in priority order keeps the earlier direction on ties.
            for (int p = 0; p < 4; p++) begin
                w_d = dir_t'(DIR_PRIO[p]);
                if (w_allowed[w_d] && (!w_found || (w_cost[w_d] < w_best_cost))) begin
                    w_sel       = w_d;
                    w_best_cost = w_cost[w_d];
                    w_found     = 1'b1;
                end
            end
        end
    end

    assign o_dir   = w_sel;
    assign o_found = w_found;
endmodule

// File: rtl/ghost_target_fsm.sv
// ghost_target_fsm: per-ghost AI core. SCATTER/CHASE/FRIGHTENED mode FSM with
// mode timer, target generation and a registered direction output.
//   clk    : system clock
//   reset  : asynchronous, active-low
//   bus    : ghost_target_fsm_if.slave (strobes, Pac-Man/ghost tiles, maze
//            legality in; dir_to_move, dir_valid, mode out). The interface
//            instance must use the same COORD_W as this module.
// Build option GHOST_FRIGHTENED_EN: when defined, adds FRIGHT mode, the
// power_pellet input, the LFSR and the mode/timer save-restore. When undefined
// power_pellet is ignored and mode is only ever SCATTER or CHASE.
// The mode register is the FSM state and is visible directly on bus.mode.
module ghost_target_fsm
    import ghost_pkg::*;
#(
    parameter int         COORD_W       = 5,
    parameter int         LOOKAHEAD     = 4,
    parameter int         SCATTER_X     = 0,
    parameter int         SCATTER_Y     = 0,
    parameter int         SCATTER_TICKS = 7,
    parameter int         CHASE_TICKS   = 20,
    parameter int         FRIGHT_TICKS  = 6,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    ghost_target_fsm_if.slave bus
);
    localparam int MAX_SC = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
    localparam int MAX_T  = (MAX_SC > FRIGHT_TICKS) ? MAX_SC : FRIGHT_TICKS;
    localparam int TW     = (MAX_T > 2) ? $clog2(MAX_T) : 1;
    localparam int C_MAX  = (1 << COORD_W) - 1;

    function automatic logic [TW-1:0] last_tick(input mode_t m);
        case (m)
            MODE_CHASE:  return TW'(CHASE_TICKS - 1);
            MODE_FRIGHT: return TW'(FRIGHT_TICKS - 1);
            default:     return TW'(SCATTER_TICKS - 1);
        endcase
    endfunction

    mode_t              r_mode, w_mode_nxt;
    logic [TW-1:0]      r_timer, w_timer_nxt;
    logic               r_pend, w_pend_nxt;
    logic               w_mode_chg;
    dir_t               r_dir;
    logic               r_valid;
    logic               w_fright;
    dir_t               w_rand_dir;
    dir_t               w_sel_dir;
    logic               w_found;
    int                 w_ax, w_ay;
    logic [COORD_W-1:0] w_chase_x, w_chase_y;
    logic [COORD_W-1:0] w_tgt_x, w_tgt_y;

`ifdef GHOST_FRIGHTENED_EN
    logic [7:0]    r_lfsr, w_lfsr_nxt;
    mode_t         r_saved_mode, w_saved_mode_nxt;
    logic [TW-1:0] r_saved_timer, w_saved_timer_nxt;

    assign w_fright   = (r_mode == MODE_FRIGHT);
    assign w_rand_dir = dir_t'(r_lfsr[1:0]);
    // The current LFSR value picks this step's direction; it then advances.
    assign w_lfsr_nxt = (bus.step_en && w_fright) ? lfsr_step(r_lfsr) : r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr        <= LFSR_SEED;
            r_saved_mode  <= MODE_SCATTER;
            r_saved_timer <= '0;
        end else begin
            r_lfsr        <= w_lfsr_nxt;
            r_saved_mode  <= w_saved_mode_nxt;
            r_saved_timer <= w_saved_timer_nxt;
        end
    end
`else
    logic       w_unused_pellet;
    logic [7:0] w_unused_seed;
    assign w_unused_pellet = bus.power_pellet;
    assign w_unused_seed   = LFSR_SEED;
    assign w_fright        = 1'b0;
    assign w_rand_dir      = DIR_UP;
`endif

    // Mode FSM next state. A pellet outranks a tick arriving in the same cycle.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_timer_nxt = r_timer;
        w_mode_chg  = 1'b0;
`ifdef GHOST_FRIGHTENED_EN
        w_saved_mode_nxt  = r_saved_mode;
        w_saved_timer_nxt = r_saved_timer;
        if (bus.power_pellet) begin
            if (r_mode != MODE_FRIGHT) begin
                w_saved_mode_nxt  = r_mode;
                w_saved_timer_nxt = r_timer;
                w_mode_nxt        = MODE_FRIGHT;
                w_mode_chg        = 1'b1;
            end
            w_timer_nxt = '0;
        end else if (bus.tick) begin
`else
        if (bus.tick) begin
`endif
            if (r_timer == last_tick(r_mode)) begin
                w_mode_chg  = 1'b1;
                w_timer_nxt = '0;
                case (r_mode)
                    MODE_SCATTER: w_mode_nxt = MODE_CHASE;
                    MODE_CHASE:   w_mode_nxt = MODE_SCATTER;
`ifdef GHOST_FRIGHTENED_EN
                    // Resume the interrupted mode where its timer paused.
                    MODE_FRIGHT: begin
                        w_mode_nxt  = r_saved_mode;
                        w_timer_nxt = r_saved_timer;
                    end
`endif
                    default:      w_mode_nxt = MODE_SCATTER;
                endcase
            end else begin
                w_timer_nxt = r_timer + TW'(1);
            end
        end
    end

    // A mode change arriving with a step re-arms the reverse for the next step.
    assign w_pend_nxt = w_mode_chg ? 1'b1 : (bus.step_en ? 1'b0 : r_pend);

    // Chase target: Pac-Man tile pushed LOOKAHEAD along his heading, clamped.
    always_comb begin
        w_ax = int'(bus.pac_x);
        w_ay = int'(bus.pac_y);
        case (dir_t'(bus.pac_dir))
            DIR_UP:    w_ay = w_ay - LOOKAHEAD;
            DIR_RIGHT: w_ax = w_ax + LOOKAHEAD;
            DIR_DOWN:  w_ay = w_ay + LOOKAHEAD;
            default:   w_ax = w_ax - LOOKAHEAD;
        endcase
        if (w_ax < 0)          w_chase_x = '0;
        else if (w_ax > C_MAX) w_chase_x = '1;
        else                   w_chase_x = w_ax[COORD_W-1:0];
        if (w_ay < 0)          w_chase_y = '0;
        else if (w_ay > C_MAX) w_chase_y = '1;
        else                   w_chase_y = w_ay[COORD_W-1:0];
    end

    assign w_tgt_x = (r_mode == MODE_CHASE) ? w_chase_x : COORD_W'(SCATTER_X);
    assign w_tgt_y = (r_mode == MODE_CHASE) ? w_chase_y : COORD_W'(SCATTER_Y);

    ghost_dir_select #(
        .COORD_W (COORD_W)
    ) u_dir_select (
        .i_ghost_x   (bus.ghost_x),
        .i_ghost_y   (bus.ghost_y),
        .i_tgt_x     (w_tgt_x),
        .i_tgt_y     (w_tgt_y),
        .i_can_move  ({bus.can_move_l, bus.can_move_d, bus.can_move_r, bus.can_move_u}),
        .i_cur_dir   (r_dir),
        .i_force_rev (r_pend),
        .i_fright    (w_fright),
        .i_rand_dir  (w_rand_dir),
        .o_dir       (w_sel_dir),
        .o_found     (w_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= MODE_SCATTER;
            r_timer <= '0;
            r_pend  <= 1'b0;
            r_dir   <= DIR_LEFT;
            r_valid <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_timer <= w_timer_nxt;
            r_pend  <= w_pend_nxt;
            r_valid <= bus.step_en;
            if (bus.step_en && w_found) begin
                r_dir <= w_sel_dir;
            end
        end
    end

    assign bus.dir_to_move = r_dir;
    assign bus.dir_valid   = r_valid;
    assign bus.mode        = r_mode;
endmodule

// File: tb/tb_ghost_target_fsm.sv
module tb_ghost_target_fsm;
    localparam int CW   = 5;
    localparam int LA   = 4;
    localparam int SX   = 0;
    localparam int SY   = 0;
    localparam int SC_T = 7;
    localparam int CH_T = 20;
    localparam int FR_T = 6;
    localparam int CMAX = 31;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    ghost_target_fsm_if #(.COORD_W(CW)) bus();

    ghost_target_fsm #(
        .COORD_W       (CW),
        .LOOKAHEAD     (LA),
        .SCATTER_X     (SX),
        .SCATTER_Y     (SY),
        .SCATTER_TICKS (SC_T),
        .CHASE_TICKS   (CH_T),
        .FRIGHT_TICKS  (FR_T),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_mode, m_timer, m_sv_mode, m_sv_timer, m_dir, m_lfsr;
    bit m_pend, m_valid;
    int lim[3] = '{SC_T, CH_T, FR_T};

    task automatic model_reset();
        m_mode = 0; m_timer = 0; m_sv_mode = 0; m_sv_timer = 0;
        m_dir = 3; m_lfsr = 'hA5; m_pend = 0; m_valid = 0;
    endtask

    // One clock edge of the game rules, using the inputs present at the edge.
    task automatic model_step();
        int  ord[4] = '{0, 3, 2, 1};
        int  ddx[4] = '{0, 1, 0, -1};
        int  ddy[4] = '{-1, 0, 1, 0};
        int  gx, gy, tx, ty, rev, d, best, bcost, cost, cx, cy, lsb;
        bit  legal[4];
        bit  allow[4];
        bit  any;
        gx = int'(bus.ghost_x);
        gy = int'(bus.ghost_y);
        if (bus.step_en) begin
            legal[0] = bus.can_move_u && (gy > 0);
            legal[1] = bus.can_move_r && (gx < CMAX);
            legal[2] = bus.can_move_d && (gy < CMAX);
            legal[3] = bus.can_move_l && (gx > 0);
            rev = (m_dir + 2) % 4;
            if (m_pend && legal[rev]) begin
                m_dir = rev;
            end else begin
                any = 0;
                for (int i = 0; i < 4; i++) begin
                    allow[i] = legal[i] && (i != rev);
                    any = any | allow[i];
                end
                if (!any) for (int i = 0; i < 4; i++) allow[i] = legal[i];
                best = -1;
                if (m_mode == 2) begin
                    for (int k = 0; k < 4; k++) begin
                        d = (m_lfsr % 4 + k) % 4;
                        if (best < 0 && allow[d]) best = d;
                    end
                end else begin
                    if (m_mode == 1) begin
                        tx = int'(bus.pac_x) + LA * ddx[bus.pac_dir];
                        ty = int'(bus.pac_y) + LA * ddy[bus.pac_dir];
                        tx = (tx < 0) ? 0 : ((tx > CMAX) ? CMAX : tx);
                        ty = (ty < 0) ? 0 : ((ty > CMAX) ? CMAX : ty);
                    end else begin
                        tx = SX; ty = SY;
                    end
                    bcost = 0;
                    for (int p = 0; p < 4; p++) begin
                        d = ord[p];
                        cx = gx + ddx[d];
                        cy = gy + ddy[d];
                        cost = (cx - tx) * (cx - tx) + (cy - ty) * (cy - ty);
                        if (allow[d] && (best < 0 || cost < bcost)) begin
                            best = d; bcost = cost;
                        end
                    end
                end
                if (best >= 0) m_dir = best;
            end
            if (m_mode == 2) begin
                lsb = m_lfsr % 2;
                m_lfsr = m_lfsr / 2;
                if (lsb == 1) m_lfsr = m_lfsr ^ 'hB8;
            end
            m_pend = 0;
        end
        m_valid = bus.step_en;
`ifdef GHOST_FRIGHTENED_EN
        if (bus.power_pellet) begin
            if (m_mode != 2) begin
                m_sv_mode = m_mode; m_sv_timer = m_timer; m_mode = 2; m_pend = 1;
            end
            m_timer = 0;
        end else
`endif
        if (bus.tick) begin
            m_timer++;
            if (m_timer == lim[m_mode]) begin
                m_pend = 1;
                if (m_mode == 2) begin
                    m_mode = m_sv_mode; m_timer = m_sv_timer;
                end else begin
                    m_mode = 1 - m_mode; m_timer = 0;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_pos(input int gx, gy, px, py, pd, cu, cr, cd, cl);
        bus.ghost_x = CW'(gx); bus.ghost_y = CW'(gy);
        bus.pac_x = CW'(px); bus.pac_y = CW'(py); bus.pac_dir = 2'(pd);
        bus.can_move_u = cu[0]; bus.can_move_r = cr[0];
        bus.can_move_d = cd[0]; bus.can_move_l = cl[0];
    endtask

    task automatic cycle(input bit t, input bit s, input bit p);
        bus.tick = t; bus.step_en = s; bus.power_pellet = p;
        @(posedge clk);
        model_step();
        #1;
        check("valid", bus.dir_valid, int'(m_valid));
        check("dir", bus.dir_to_move, m_dir);
        check("mode", bus.mode, m_mode);
        bus.tick = 0; bus.step_en = 0; bus.power_pellet = 0;
    endtask

    task automatic rand_cycle();
        int gx, gy;
        gx = (($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) * CMAX) : $urandom_range(0, CMAX));
        gy = (($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) * CMAX) : $urandom_range(0, CMAX));
        set_pos(gx, gy, $urandom_range(0, CMAX), $urandom_range(0, CMAX), $urandom_range(0, 3),
                int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3) != 0));
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.tick = 0; bus.step_en = 0; bus.power_pellet = 0;
        set_pos(10, 20, 10, 10, 0, 1, 1, 1, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dir", bus.dir_to_move, 3);
        check("rst_mode", bus.mode, 0);
        check("rst_valid", bus.dir_valid, 0);

        // SCATTER -> CHASE, then the first step reverses LEFT to RIGHT.
        repeat (SC_T) cycle(1, 0, 0);
        check("scatter_to_chase", bus.mode, 1);
        cycle(0, 1, 0);
        check("rev_on_chase", bus.dir_to_move, 1);
        // Target (10,6) from ghost (10,20): UP.
        cycle(0, 1, 0);
        check("chase_up", bus.dir_to_move, 0);
        // Target x clamps to 31: RIGHT (a wrapped target would give LEFT).
        set_pos(28, 2, 30, 2, 1, 1, 1, 1, 1);
        cycle(0, 1, 0);
        check("clamp_x", bus.dir_to_move, 1);
        // Target (5,5) at the ghost; DOWN and RIGHT tie, DOWN wins.
        set_pos(5, 5, 5, 9, 0, 0, 1, 1, 0);
        cycle(0, 1, 0);
        check("tie_down", bus.dir_to_move, 2);
        // CHASE -> SCATTER, first step reverses DOWN to UP.
        set_pos(10, 10, 10, 10, 0, 1, 1, 1, 1);
        repeat (CH_T) cycle(1, 0, 0);
        check("chase_to_scatter", bus.mode, 0);
        cycle(0, 1, 0);
        check("rev_on_scatter", bus.dir_to_move, 0);
        // Nowhere to go: direction held, still a valid pulse.
        set_pos(10, 10, 10, 10, 0, 0, 0, 0, 0);
        cycle(0, 1, 0);
        check("hold_dir", bus.dir_to_move, 0);
        check("hold_valid", bus.dir_valid, 1);
        cycle(0, 0, 0);
        check("valid_drop", bus.dir_valid, 0);

`ifdef GHOST_FRIGHTENED_EN
        set_pos(10, 10, 10, 10, 0, 1, 1, 1, 1);
        repeat (SC_T) cycle(1, 0, 0);
        repeat (12) cycle(1, 0, 0);
        cycle(0, 0, 1);
        check("pellet_fright", bus.mode, 2);
        repeat (FR_T - 1) cycle(1, 0, 0);
        check("fright_hold", bus.mode, 2);
        cycle(1, 0, 0);
        check("fright_restore", bus.mode, 1);
        repeat (CH_T - 12 - 1) cycle(1, 0, 0);
        check("resume_still_chase", bus.mode, 1);
        cycle(1, 0, 0);
        check("resume_to_scatter", bus.mode, 0);
`endif

        repeat (2000) rand_cycle();

        // Asynchronous reset in the middle of a clock period.
        set_pos(10, 10, 10, 10, 0, 1, 1, 1, 1);
        cycle(0, 1, 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_dir", bus.dir_to_move, 3);
        check("async_rst_mode", bus.mode, 0);
        check("async_rst_valid", bus.dir_valid, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (500) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
